// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART blocks.
//   UART_DW    : serial data word width (8).
//   START_BIT  : line level of the start bit (0).
//   STOP_BIT   : line level of the stop bit and of the idle line (1).
//   uart_state_e : 3-bit transmitter state encoding, IDLE=0 .. STOP=6.
package uart_pkg;

    localparam int unsigned UART_DW = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
//   clk   : system clock, rising edge.
//   rst   : synchronous active-high reset, clears the count.
//   clear : synchronous clear, holds the count at 0 while high.
//   tick  : high during the last cycle (count == CLKS_PER_BIT-1) of a bit period.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = w_last && !clear;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains an 8-bit synchronous FIFO one byte at a time and sends
// each byte as a serial frame: start, 8 data bits LSB first, optional even
// parity, stop.
//   clk      : system clock, rising edge.
//   rst      : synchronous active-high reset.
//   empty    : FIFO empty flag, looked at only while idle.
//   data_out : FIFO read data, valid the cycle after rd_en was sampled.
//   rd_en    : registered one-cycle FIFO pop strobe.
//   tx       : serial line, idles high.
//   busy     : high from the pop decision until the end of the stop bit.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               empty,
    input  logic [UART_DW-1:0] data_out,
    output logic               rd_en,
    output logic               tx,
    output logic               busy
);

    uart_state_e        r_state;
    logic [UART_DW-1:0] r_shreg;
    logic               r_par;
    logic [2:0]         r_bit_idx;
    logic               r_tx;
    logic               r_rd_en;
    logic               r_busy;

    logic               w_clear;
    logic               w_tick;

    // Baud timing only runs while a bit is on the line, so the first bit
    // period after LOAD starts from a zero count.
    assign w_clear = (r_state == IDLE) || (r_state == POP) || (r_state == LOAD);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    assign tx    = r_tx;
    assign rd_en = r_rd_en;
    assign busy  = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_par     <= 1'b0;
            r_bit_idx <= '0;
            r_tx      <= STOP_BIT;
            r_rd_en   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= STOP_BIT;
                    r_busy <= 1'b0;
                    if (!empty) begin
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= POP;
                    end
                end
                POP: begin
                    r_rd_en <= 1'b0;
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_shreg   <= data_out;
                    r_par     <= 1'b0;
                    r_bit_idx <= '0;
                    r_tx      <= START_BIT;
                    r_state   <= START;
                end
                START: begin
                    // Parity accumulates each data bit as it is put on the line.
                    if (w_tick) begin
                        r_tx      <= r_shreg[0];
                        r_par     <= r_par ^ r_shreg[0];
                        r_shreg   <= r_shreg >> 1;
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_par;
                                r_state <= PARITY;
                            end else begin
                                r_tx    <= STOP_BIT;
                                r_state <= STOP;
                            end
                        end else begin
                            r_tx      <= r_shreg[0];
                            r_par     <= r_par ^ r_shreg[0];
                            r_shreg   <= r_shreg >> 1;
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_tx    <= STOP_BIT;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_tx    <= STOP_BIT;
                    r_rd_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4.
// dut0 runs without parity, dut1 with even parity; each drains its own
// queue-based FIFO model. Expected line levels come from the frame format.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       empty0 = 1'b1, empty1 = 1'b1;
    logic [7:0] dout0 = '0, dout1 = '0;
    logic       rd_en0, rd_en1, tx0, tx1, busy0, busy1;
    logic [1:0] push_v = '0;
    logic [7:0] push_b = '0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         rd_cnt0 = 0, rd_cnt1 = 0;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .empty(empty0), .data_out(dout0),
        .rd_en(rd_en0), .tx(tx0), .busy(busy0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .empty(empty1), .data_out(dout1),
        .rd_en(rd_en1), .tx(tx1), .busy(busy1)
    );

    // Synchronous FIFO models: registered empty, read data one cycle after rd_en.
    always @(posedge clk) begin
        if (push_v[0]) q0.push_back(push_b);
        if (push_v[1]) q1.push_back(push_b);
        if (rd_en0) begin
            rd_cnt0++;
            if (q0.size() > 0) dout0 <= q0.pop_front();
        end
        if (rd_en1) begin
            rd_cnt1++;
            if (q1.size() > 0) dout1 <= q1.pop_front();
        end
        empty0 <= (q0.size() == 0);
        empty1 <= (q1.size() == 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic tx_of(input int sel);
        return (sel == 1) ? tx1 : tx0;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 1) ? busy1 : busy0;
    endfunction

    function automatic logic rd_of(input int sel);
        return (sel == 1) ? rd_en1 : rd_en0;
    endfunction

    function automatic int rdcnt_of(input int sel);
        return (sel == 1) ? rd_cnt1 : rd_cnt0;
    endfunction

    // Line level for frame bit position idx: start, D0..D7, [parity], stop.
    function automatic logic exp_bit(input logic [7:0] b, input bit pen, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (pen && idx == 9) return ^b;
        return 1'b1;
    endfunction

    // Called at a negedge; pushes one byte at the next posedge.
    task automatic push_byte(input int sel, input logic [7:0] b);
        push_b      = b;
        push_v[sel] = 1'b1;
        @(negedge clk);
        push_v = '0;
    endtask

    // Waits for the start bit, then checks every cycle of the frame and the
    // first idle cycle after it. Optionally pushes inj_b at frame cycle inj_cycle.
    task automatic capture_frame(input int sel, input logic [7:0] b,
                                 input int inj_cycle, input logic [7:0] inj_b);
        bit pen;
        int nb;
        int budget;
        pen    = (sel == 1);
        nb     = pen ? 11 : 10;
        budget = 0;
        while (tx_of(sel) !== 1'b0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (tx_of(sel) !== 1'b0) begin
            errors++;
            $display("FAIL start_timeout sel=%0d byte=%02h: tx=%b, required 0 within 200 cycles",
                     sel, b, tx_of(sel));
            return;
        end
        for (int k = 0; k < nb * 4; k++) begin
            push_b      = inj_b;
            push_v[sel] = (k == inj_cycle);
            checks++;
            if ({tx_of(sel), busy_of(sel)} !== {exp_bit(b, pen, k / 4), 1'b1}) begin
                errors++;
                $display("FAIL frame_bit sel=%0d byte=%02h cycle=%0d: tx,busy=%b%b, required %b1",
                         sel, b, k, tx_of(sel), busy_of(sel), exp_bit(b, pen, k / 4));
            end
            @(negedge clk);
        end
        push_v = '0;
        checks++;
        if (tx_of(sel) !== 1'b1 || busy_of(sel) !== 1'b0) begin
            errors++;
            $display("FAIL frame_end sel=%0d byte=%02h: tx,busy=%b%b, required 10",
                     sel, b, tx_of(sel), busy_of(sel));
        end
    endtask

    // Starts at the first idle cycle after a frame; counts high cycles to the next start bit.
    task automatic check_gap(input int sel);
        int n;
        n = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_of(sel) === 1'b0) break;
            n++;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL gap sel=%0d: idle-high cycles=%0d, required 3", sel, n);
        end
    endtask

    task automatic check_idle(input int sel, input int cycles, input string name);
        for (int i = 0; i < cycles; i++) begin
            checks++;
            if ({tx_of(sel), rd_of(sel), busy_of(sel)} !== 3'b100) begin
                errors++;
                $display("FAIL %s sel=%0d cycle=%0d: tx,rd_en,busy=%b%b%b, required 100",
                         name, sel, i, tx_of(sel), rd_of(sel), busy_of(sel));
            end
            @(negedge clk);
        end
    endtask

    task automatic check_pops(input int sel, input int got, input int want, input string name);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s sel=%0d: rd_en cycles=%0d, required %0d", name, sel, got, want);
        end
    endtask

    task automatic test_reset();
        int c0, c1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        c0 = rd_cnt0;
        c1 = rd_cnt1;
        for (int i = 0; i < 100; i++) begin
            checks++;
            if ({tx0, rd_en0, busy0, tx1, rd_en1, busy1} !== 6'b100100) begin
                errors++;
                $display("FAIL reset_idle cycle=%0d: dut0=%b%b%b dut1=%b%b%b, required 100 100",
                         i, tx0, rd_en0, busy0, tx1, rd_en1, busy1);
            end
            @(negedge clk);
        end
        check_pops(0, rd_cnt0 - c0, 0, "reset_no_pop");
        check_pops(1, rd_cnt1 - c1, 0, "reset_no_pop");
    endtask

    task automatic test_single_noparity();
        int c;
        c = rd_cnt0;
        push_byte(0, 8'hA5);
        capture_frame(0, 8'hA5, -1, 8'h00);
        check_pops(0, rd_cnt0 - c, 1, "single_pop");
    endtask

    task automatic test_single_parity();
        int c;
        c = rd_cnt1;
        push_byte(1, 8'hA5);
        capture_frame(1, 8'hA5, -1, 8'h00);
        push_byte(1, 8'h07);
        capture_frame(1, 8'h07, -1, 8'h00);
        check_pops(1, rd_cnt1 - c, 2, "parity_pops");
    endtask

    task automatic test_back_to_back();
        int c;
        c = rd_cnt0;
        push_byte(0, 8'h01);
        push_byte(0, 8'h80);
        push_byte(0, 8'hFF);
        capture_frame(0, 8'h01, -1, 8'h00);
        check_gap(0);
        capture_frame(0, 8'h80, -1, 8'h00);
        check_gap(0);
        capture_frame(0, 8'hFF, -1, 8'h00);
        @(negedge clk);
        check_idle(0, 20, "b2b_idle");
        check_pops(0, rd_cnt0 - c, 3, "b2b_pops");
    endtask

    task automatic test_random();
        logic [7:0] bytes[4];
        for (int sel = 0; sel < 2; sel++) begin
            for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 4; i++) push_byte(sel, bytes[i]);
            for (int i = 0; i < 4; i++) begin
                capture_frame(sel, bytes[i], -1, 8'h00);
                if (i < 3) check_gap(sel);
            end
            @(negedge clk);
            check_idle(sel, 5, "random_idle");
        end
    endtask

    task automatic test_reset_mid_frame();
        int c;
        int budget;
        c = rd_cnt0;
        push_byte(0, 8'h3C);
        push_byte(0, 8'h55);
        budget = 0;
        while (tx0 !== 1'b0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        // Frame cycles 16..19 carry data bit 3.
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx0, rd_en0, busy0} !== 3'b100) begin
            errors++;
            $display("FAIL midframe_reset: tx,rd_en,busy=%b%b%b, required 100", tx0, rd_en0, busy0);
        end
        rst = 1'b0;
        capture_frame(0, 8'h55, -1, 8'h00);
        @(negedge clk);
        check_idle(0, 60, "midframe_no_retx");
        check_pops(0, rd_cnt0 - c, 2, "midframe_pops");
    endtask

    task automatic test_late_write();
        logic [7:0] b;
        int         c;
        b = 8'($urandom_range(0, 255));
        c = rd_cnt0;
        push_byte(0, b);
        // Frame cycle 37 lies inside the stop bit (cycles 36..39).
        capture_frame(0, b, 37, 8'h42);
        check_gap(0);
        capture_frame(0, 8'h42, -1, 8'h00);
        check_pops(0, rd_cnt0 - c, 2, "late_pops");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_noparity();
        test_single_parity();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        test_late_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial drain stage that sits directly downstream of the 8-bit synchronous `fifo`. It pops one byte at a time through the FIFO read port (`rd_en`, `data_out`, `empty`) and shifts each byte out as an asynchronous serial frame on `tx`. The frame is 1 start bit, 8 data bits LSB first, an optional even-parity bit, and 1 stop bit. It is the only reader of the FIFO; the FIFO write side belongs to the upstream producer.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit; legal range ≥ 2.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit between D7 and stop.
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `empty`  in  1  FIFO empty flag.
- `data_out`  in  8  FIFO read data. It is valid the cycle after the edge that sampled `rd_en`=1.
- `rd_en`  out  1  FIFO pop strobe; registered.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high from the pop decision until the end of the stop bit.

## Operation
- States: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- **IDLE**: `tx`=1 and `busy`=0. If `empty`=0 at an edge, that edge sets `rd_en`<=1 and `busy`<=1, and moves to POP.
- **POP**: the FIFO samples `rd_en`=1 at this edge. The block sets `rd_en`<=0 and moves to LOAD. `rd_en` is high for exactly one cycle per byte, so exactly one pop happens per frame.
- **LOAD**: captures `data_out` into the shift register, clears the parity accumulator, sets `tx`<=0 and moves to START.
- **START**, **DATA**, **PARITY**, **STOP**: each bit lasts `CLKS_PER_BIT` cycles, timed by the baud counter.
  - DATA shifts right and drives `tx` = shreg[0] for bits 0..7. The bit index runs 0–7.
  - When `PARITY_EN`=1, PARITY drives the XOR of the 8 data bits. With `PARITY_EN`=0 the PARITY state is skipped.
  - STOP drives 1.
- **End of STOP**: returns to IDLE with `busy`<=0. The `empty` flag is re-evaluated only in IDLE, so a byte written during a frame is picked up after that frame.
- **Arithmetic**:
  - Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and produces a bit-end tick at CLKS_PER_BIT-1.
  - Bit index is 3 bits.
- **Reset mid-frame**: the next edge forces IDLE, `tx`=1, `rd_en`=0, `busy`=0 and clears the counters. A byte already popped is discarded, not re-read.
- **`empty` deasserting during POP or LOAD**: ignored. The popped byte is still sent.

## Timing
- **Reset values**: `tx`=1, `rd_en`=0, `busy`=0, state IDLE, counters 0.
- **Pop latency**: `rd_en` rises 1 cycle after the edge that sees `empty`=0. `tx` falls 2 cycles after `rd_en` rises.
- **Frame length**: (10+`PARITY_EN`)×`CLKS_PER_BIT` cycles, from the `tx` falling edge to the end of the stop bit.
- **Inter-frame gap**: with the FIFO non-empty, there are exactly 3 idle-high cycles (IDLE, POP, LOAD) between the end of a stop bit and the next start bit.
- **`empty` timing**: `empty` is sampled only in IDLE. `data_out` is sampled only in LOAD.

## Structure
- Shared package `uart_pkg` holds:
  - the 3-bit state encodings (IDLE=0 … STOP=6);
  - the frame constants `START_BIT`=0 and `STOP_BIT`=1;
  - the data width `UART_DW`=8.
- One sub-module, `uart_baud_tick`, is natural. It is the `CLKS_PER_BIT` counter with a synchronous `clear` input and a one-cycle `tick` output. The same sub-module is reused by the future receiver.
- The top level holds the FSM, the shift register, the parity accumulator and the bit index.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- **Reset, then idle**: assert `rst` for 3 cycles with FIFO `empty`=1 for 100 cycles → `tx`=1, `rd_en`=0 and `busy`=0 throughout, and no pop ever occurs.
- **Single byte, `PARITY_EN`=0**: push 0xA5 → `rd_en` is high for exactly 1 cycle. `tx` carries 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total). Then `busy`=0.
- **Single byte, `PARITY_EN`=1**:
  - push 0xA5 → the parity bit is 0 and the frame is 44 cycles;
  - push 0x07 → the parity bit is 1.
- **Back-to-back**: preload 0x01, 0x80, 0xFF → three frames in order, exactly 3 high cycles between frames, and exactly 3 `rd_en` pulses. After that, `empty`=1 and the block stays idle.
- **Reset mid-frame**: assert `rst` during DATA bit 3 of 0x3C → `tx`=1 on the following cycle. After reset releases, the next queued byte (0x55) is sent complete. 0x3C is not retransmitted.
- **Late write**: write 0x42 while the block is in STOP of a previous frame → 0x42 is popped after the STOP ends, and its start bit follows the 3-cycle gap.
